// File: rtl/pc_sequencer.sv
// Program-counter sequencer with INC/JUMP/BRANCH/CALL/RET and a circular return-address stack.
// Single-cycle update; callers stall by holding pc_update_en_in low, and the block never pushes back.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    ALIGN_BITS   = 1,
  parameter int                    STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               clk_in,
  input  logic                               reset_in,
  input  logic                               pc_update_en_in,
  input  logic [2:0]                         pc_op_in,
  input  logic [ADDR_WIDTH-1:0]              target_addr_in,
  input  logic [ADDR_WIDTH-1:0]              branch_offset_in,
  input  logic                               err_clear_in,
  output logic [ADDR_WIDTH-1:0]              pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth_out,
  output logic                               stack_empty_out,
  output logic                               stack_full_out,
  output logic                               overflow_err_out,
  output logic                               underflow_err_out
);

  localparam int PW  = ADDR_WIDTH - ALIGN_BITS;
  localparam int DW  = $clog2(STACK_DEPTH + 1);
  localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [SPW-1:0] LAST_SLOT = SPW'(STACK_DEPTH - 1);
  localparam logic [PW-1:0]  RESET_PC  = PW'(RESET_VECTOR >> ALIGN_BITS);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [PW-1:0]         pc_q;
  logic [PW-1:0]         stack_q [STACK_DEPTH];
  logic [SPW-1:0]        wr_ptr_q;
  logic [DW-1:0]         depth_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic [PW-1:0]         pc_inc;
  logic [PW-1:0]         target_pc;
  logic [PW-1:0]         branch_pc;
  logic [ADDR_WIDTH-1:0] branch_sum;
  logic [SPW-1:0]        wr_ptr_next;
  logic [SPW-1:0]        rd_ptr;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  do_call;
  logic                  do_ret;

  always_comb begin
    pc_inc      = pc_q + PW'(1);
    target_pc   = PW'(target_addr_in >> ALIGN_BITS);
    branch_sum  = pc_out + branch_offset_in;
    branch_pc   = PW'(branch_sum >> ALIGN_BITS);
    // wr_ptr_q is the next free slot; a full stack wraps onto its oldest entry
    wr_ptr_next = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + SPW'(1);
    rd_ptr      = (wr_ptr_q == '0) ? LAST_SLOT : wr_ptr_q - SPW'(1);
    stack_full  = (depth_q == DW'(STACK_DEPTH));
    stack_empty = (depth_q == '0);
    do_call     = pc_update_en_in && (pc_op_in == OP_CALL);
    do_ret      = pc_update_en_in && (pc_op_in == OP_RET);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pc_q        <= RESET_PC;
      wr_ptr_q    <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (overflow_q  & ~err_clear_in) | (do_call & stack_full);
      underflow_q <= (underflow_q & ~err_clear_in) | (do_ret  & stack_empty);
      if (pc_update_en_in) begin
        case (pc_op_in)
          OP_INC:    pc_q <= pc_inc;
          OP_JUMP:   pc_q <= target_pc;
          OP_BRANCH: pc_q <= branch_pc;
          OP_CALL: begin
            pc_q     <= target_pc;
            wr_ptr_q <= wr_ptr_next;
            if (!stack_full) depth_q <= depth_q + DW'(1);
          end
          OP_RET: begin
            if (!stack_empty) begin
              pc_q     <= stack_q[rd_ptr];
              wr_ptr_q <= rd_ptr;
              depth_q  <= depth_q - DW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in && do_call) stack_q[wr_ptr_q] <= pc_inc;
  end

  assign pc_out            = ADDR_WIDTH'(pc_q) << ALIGN_BITS;
  assign stack_depth_out   = depth_q;
  assign stack_empty_out   = stack_empty;
  assign stack_full_out    = stack_full;
  assign overflow_err_out  = overflow_q;
  assign underflow_err_out = underflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector table plus randomized run against a queue-based PC/stack model.
module tb_pc_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        pc_update_en_in;
  logic [2:0]  pc_op_in;
  logic [15:0] target_addr_in;
  logic [15:0] branch_offset_in;
  logic        err_clear_in;
  logic [15:0] pc_out;
  logic [2:0]  stack_depth_out;
  logic        stack_empty_out;
  logic        stack_full_out;
  logic        overflow_err_out;
  logic        underflow_err_out;

  pc_sequencer #(
    .ADDR_WIDTH  (16),
    .ALIGN_BITS  (1),
    .STACK_DEPTH (4),
    .RESET_VECTOR(16'h0100)
  ) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .pc_update_en_in  (pc_update_en_in),
    .pc_op_in         (pc_op_in),
    .target_addr_in   (target_addr_in),
    .branch_offset_in (branch_offset_in),
    .err_clear_in     (err_clear_in),
    .pc_out           (pc_out),
    .stack_depth_out  (stack_depth_out),
    .stack_empty_out  (stack_empty_out),
    .stack_full_out   (stack_full_out),
    .overflow_err_out (overflow_err_out),
    .underflow_err_out(underflow_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst;
    logic        en;
    logic [2:0]  op;
    logic [15:0] tgt;
    logic [15:0] off;
    logic        clr;
    logic [15:0] pc;
    int          depth;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: byte-address PC, return addresses kept oldest-first.
  int m_pc;
  int m_stk[$];
  bit m_ovf;
  bit m_unf;

  function automatic vec_t mk(logic rst, logic en, logic [2:0] op, logic [15:0] tgt,
                              logic [15:0] off, logic clr, logic [15:0] pc, int depth,
                              logic ovf, logic unf);
    vec_t v;
    v.rst = rst; v.en = en; v.op = op; v.tgt = tgt; v.off = off; v.clr = clr;
    v.pc = pc; v.depth = depth; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  function automatic void model_step(logic rst, logic en, logic [2:0] op, logic [15:0] tgt,
                                     logic [15:0] off, logic clr);
    bit set_o = 0;
    bit set_u = 0;
    if (rst) begin
      m_pc = 'h0100;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    if (en) begin
      case (op)
        3'd0: m_pc = (m_pc + 2) % 65536;
        3'd1: m_pc = int'(tgt) & 'hFFFE;
        3'd2: m_pc = (m_pc + int'(off)) & 'hFFFE;
        3'd3: begin
          if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            set_o = 1;
          end
          m_stk.push_back((m_pc + 2) % 65536);
          m_pc = int'(tgt) & 'hFFFE;
        end
        3'd4: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else set_u = 1;
        end
        default: ;
      endcase
    end
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (set_o) m_ovf = 1;
    if (set_u) m_unf = 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    32'(pc_out),            32'(m_pc));
    check({tag, ".depth"}, 32'(stack_depth_out),   32'(m_stk.size()));
    check({tag, ".empty"}, 32'(stack_empty_out),   32'(m_stk.size() == 0));
    check({tag, ".full"},  32'(stack_full_out),    32'(m_stk.size() == 4));
    check({tag, ".ovf"},   32'(overflow_err_out),  32'(m_ovf));
    check({tag, ".unf"},   32'(underflow_err_out), 32'(m_unf));
  endtask

  task automatic drive(input logic rst, input logic en, input logic [2:0] op,
                       input logic [15:0] tgt, input logic [15:0] off, input logic clr);
    reset_in = rst; pc_update_en_in = en; pc_op_in = op;
    target_addr_in = tgt; branch_offset_in = off; err_clear_in = clr;
    @(posedge clk_in);
    #1;
    model_step(rst, en, op, tgt, off, clr);
  endtask

  initial begin
    logic [2:0]  op;
    logic [15:0] hold_pc;
    int          k;

    reset_in = 1'b1; pc_update_en_in = 1'b0; pc_op_in = 3'd0;
    target_addr_in = '0; branch_offset_in = '0; err_clear_in = 1'b0;

    //              rst en op    tgt       off       clr  pc        d  ovf unf
    vecs.push_back(mk(1, 0, 3'd0, 16'h0000, 16'h0000, 0, 16'h0100, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd0, 16'h0000, 16'h0000, 0, 16'h0102, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd0, 16'h0000, 16'h0000, 0, 16'h0104, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd0, 16'h0000, 16'h0000, 0, 16'h0106, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 16'hFFFE, 16'h0000, 0, 16'hFFFE, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 16'h1235, 16'h0000, 0, 16'h1234, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd2, 16'h0000, 16'hFFF0, 0, 16'h1224, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 16'h0004, 16'h0000, 0, 16'h0004, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd2, 16'h0000, 16'hFFF0, 0, 16'hFFF4, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 16'h0010, 16'h0000, 0, 16'h0010, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 16'h0200, 16'h0000, 0, 16'h0200, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 16'h0300, 16'h0000, 0, 16'h0300, 2, 0, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h0202, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h0012, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd1, 16'h1000, 16'h0000, 0, 16'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 16'h2000, 16'h0000, 0, 16'h2000, 1, 0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 16'h3000, 16'h0000, 0, 16'h3000, 2, 0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 16'h4000, 16'h0000, 0, 16'h4000, 3, 0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 16'h5000, 16'h0000, 0, 16'h5000, 4, 0, 0));
    vecs.push_back(mk(0, 1, 3'd3, 16'h6000, 16'h0000, 0, 16'h6000, 4, 1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h5002, 3, 1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h4002, 2, 1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h3002, 1, 1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h2002, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h2002, 0, 1, 1));
    vecs.push_back(mk(0, 0, 3'd0, 16'h0000, 16'h0000, 1, 16'h2002, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 1, 16'h2002, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3'd3, 16'h0400, 16'h0000, 0, 16'h0400, 1, 0, 1));
    vecs.push_back(mk(0, 1, 3'd3, 16'h0500, 16'h0000, 0, 16'h0500, 2, 0, 1));
    vecs.push_back(mk(0, 1, 3'd3, 16'h0600, 16'h0000, 0, 16'h0600, 3, 0, 1));
    vecs.push_back(mk(1, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h0100, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd4, 16'h0000, 16'h0000, 0, 16'h0100, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].tgt, vecs[i].off, vecs[i].clr);
      check($sformatf("vec%0d.pc", i),    32'(pc_out),            32'(vecs[i].pc));
      check($sformatf("vec%0d.depth", i), 32'(stack_depth_out),   32'(vecs[i].depth));
      check($sformatf("vec%0d.empty", i), 32'(stack_empty_out),   32'(vecs[i].depth == 0));
      check($sformatf("vec%0d.full", i),  32'(stack_full_out),    32'(vecs[i].depth == 4));
      check($sformatf("vec%0d.ovf", i),   32'(overflow_err_out),  32'(vecs[i].ovf));
      check($sformatf("vec%0d.unf", i),   32'(underflow_err_out), 32'(vecs[i].unf));
    end

    // Stall: INC presented for 10 cycles with the enable low must not move anything.
    hold_pc = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 3'd0, 16'h0000, 16'h0000, 0);
      check($sformatf("stall%0d.pc", i), 32'(pc_out), 32'(hold_pc));
      check_model($sformatf("stall%0d", i));
    end

    // CALL directly followed by RET returns to the call site plus one instruction.
    drive(0, 1, 3'd1, 16'h0A00, 16'h0000, 0);
    drive(0, 1, 3'd3, 16'h0C00, 16'h0000, 0);
    drive(0, 1, 3'd4, 16'h0000, 16'h0000, 0);
    check("call_ret.pc", 32'(pc_out), 32'h0A02);
    check_model("call_ret");

    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    op = 3'd0;
        2:       op = 3'd1;
        3:       op = 3'd2;
        4, 5:    op = 3'd3;
        6, 7:    op = 3'd4;
        default: op = 3'($urandom_range(5, 7));
      endcase
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, op,
            16'($urandom), 16'($urandom), $urandom_range(0, 7) == 0);
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer that generalises the core's original increment/jump PC. It adds configurable address width and instruction alignment, a programmable reset vector, PC-relative branches and a hardware return-address stack for CALL/RET, with overflow and underflow reporting. It sits between the decoder/branch unit, which supplies the operation and target, and the instruction fetch port, which consumes `pc_out`.

## Interface
- `ADDR_WIDTH`, default 16: byte-address width of the PC; must be at least `ALIGN_BITS`+2.
- `ALIGN_BITS`, default 1: log2 of instruction size in bytes; the low `ALIGN_BITS` bits of `pc_out` are always 0.
- `STACK_DEPTH`, default 4: number of return-address entries; must be at least 1.
- `RESET_VECTOR`, default 0: byte address loaded on reset; its low `ALIGN_BITS` bits are ignored.
- `clk_in`  in  1: sole clock, all state updates on its rising edge.
- `reset_in`  in  1: synchronous, active-high reset.
- `pc_update_en_in`  in  1: when 1, perform `pc_op_in` this cycle; when 0, hold all state.
- `pc_op_in`  in  3: 000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101–111 reserved (treated as hold).
- `target_addr_in`  in  ADDR_WIDTH: absolute byte target for JUMP and CALL; low `ALIGN_BITS` bits are ignored.
- `branch_offset_in`  in  ADDR_WIDTH: signed two's-complement byte offset for BRANCH; low `ALIGN_BITS` bits are ignored.
- `err_clear_in`  in  1: clears both sticky error flags.
- `pc_out`  out  ADDR_WIDTH: current PC as a byte address, `{pc_q, ALIGN_BITS'b0}`.
- `stack_depth_out`  out  $clog2(STACK_DEPTH+1): number of valid stack entries.
- `stack_empty_out`  out  1: 1 when the depth is 0.
- `stack_full_out`  out  1: 1 when the depth equals `STACK_DEPTH`.
- `overflow_err_out`  out  1: sticky flag, set by CALL while the stack is full.
- `underflow_err_out`  out  1: sticky flag, set by RET while the stack is empty.

## Operation
- State:
  - `pc_q`: ADDR_WIDTH−ALIGN_BITS bits.
  - Stack array of `STACK_DEPTH` × (ADDR_WIDTH−ALIGN_BITS) bits, with a top pointer and a depth counter.
  - The two error flags.
- Reset (`reset_in`=1) overrides everything:
  - `pc_q` ← `RESET_VECTOR[ADDR_WIDTH-1:ALIGN_BITS]`.
  - Depth ← 0; `stack_empty_out`=1, `stack_full_out`=0.
  - Both error flags ← 0.
  - Stack contents are don't-care.
- INC: `pc_q` ← `pc_q`+1, wrapping modulo 2^(ADDR_WIDTH−ALIGN_BITS); all-ones wraps to 0.
- JUMP: `pc_q` ← `target_addr_in[ADDR_WIDTH-1:ALIGN_BITS]`.
- BRANCH: `pc_q` ← (`pc_out` + `branch_offset_in`)[ADDR_WIDTH-1:ALIGN_BITS].
  - The offset is relative to the current (branch instruction) address, not PC+1.
  - The sum is computed modulo 2^ADDR_WIDTH; there is no overflow flag.
- CALL: push `pc_q`+1 (wrapped), then `pc_q` ← target.
  - If not full: depth +1.
  - If full: the jump still occurs, the oldest entry is discarded (circular overwrite), depth stays `STACK_DEPTH`, and `overflow_err_out` ← 1.
- RET: if the depth is greater than 0, `pc_q` ← top entry and depth −1.
  - If empty: `pc_q` is held (not incremented), depth stays 0, and `underflow_err_out` ← 1.
- Reserved opcodes, or `pc_update_en_in`=0: no change to PC, stack or flags.
- `err_clear_in`:
  - Clears both flags on the next edge.
  - If the same cycle also raises an error, set wins: the flag ends at 1.
- The stack is strictly LIFO. After an overflow, the most recent `STACK_DEPTH` return addresses remain valid, in order.

## Timing
- Every output is registered, or is a combinational decode of registers only. No input-to-output combinational path exists.
- An operation presented with `pc_update_en_in`=1 at edge N is visible on `pc_out`/`stack_*` immediately after edge N: single-cycle latency.
- Back-to-back operations every cycle are supported, including CALL followed directly by RET, which returns to the call site +1 instruction.
- Reset asserted mid-sequence takes effect at the next edge and discards the whole stack. The first operation after deassertion acts on `RESET_VECTOR`.
- No handshake is required. The caller holds `pc_update_en_in` low to stall, for any number of cycles.

## Test plan
- Reset and INC (defaults, `RESET_VECTOR`=0x0100):
  - Reset, then 3 INC → `pc_out` 0x0100, 0x0102, 0x0104, 0x0106.
  - Force PC to 0xFFFE via JUMP, then INC → 0x0000.
- JUMP/BRANCH alignment:
  - JUMP 0x1235 → 0x1234.
  - From 0x1234, BRANCH 0xFFF0 (−16) → 0x1224.
  - From 0x0004, BRANCH 0xFFF0 → 0xFFF4 (wrap).
- Nested CALL/RET with `STACK_DEPTH`=4:
  - From 0x0010, CALL 0x0200, then CALL 0x0300.
  - Depth reads 2; RET → 0x0202, RET → 0x0012.
  - Afterwards empty=1 and no errors.
- Overflow:
  - Perform 5 CALLs from distinct PCs A1..A5.
  - Response: `overflow_err_out`=1, full=1, depth=4.
  - Four RETs → A5+2, A4+2, A3+2, A2+2 (byte).
  - A fifth RET → PC held, `underflow_err_out`=1.
- Errors and stall:
  - With both flags set, assert `err_clear_in` alone → both flags 0.
  - Assert `err_clear_in` together with an underflowing RET → underflow=1.
  - Hold `pc_update_en_in`=0 for 10 cycles with op=INC → `pc_out` unchanged.
- Reset mid-operation:
  - After 3 CALLs, assert `reset_in` in the same cycle as a RET.
  - Response: `pc_out`=`RESET_VECTOR`, depth=0, flags 0.
  - A following RET → underflow=1.
